// File: rtl/sram_bar_player.sv
// Reads 64-bit bars back from the SRAM bar store and plays them as 16 four-bit
// notes, one note per beat, while the writer does not own the SRAM.
module sram_bar_player #(
  parameter int BEAT_CYCLES = 12000000,
  parameter int RD_LAT      = 2
) (
  input  logic        i_bclk,
  input  logic        i_rst,
  input  logic        i_mode,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_pause,
  input  logic        i_loop,
  input  logic [7:0]  i_bar_en,
  input  logic [15:0] i_SRAM_DQ,
  output logic [19:0] o_addr,
  output logic        o_oe_n,
  output logic [3:0]  o_note,
  output logic        o_note_valid,
  output logic [2:0]  o_bar,
  output logic        o_busy
);

  localparam int CNT_W = $clog2(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [2:0] CAP_FIRST = 3'(RD_LAT);
  localparam logic [2:0] CAP_LAST  = 3'(RD_LAT + 3);

  typedef enum logic [2:0] {IDLE, SEEK, FETCH, PLAY, DONE} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       fcnt;
  logic [63:0]      bar_buf;
  logic [CNT_W-1:0] beat_cnt;
  logic [3:0]       note_idx;
  logic [1:0]       cap_idx;
  logic [1:0]       iss_idx;

  // Bar b lives at word address 4+4b; the +1 keeps bar 0 clear of address 0.
  function automatic logic [19:0] word_addr(input logic [2:0] bar, input logic [1:0] k);
    return {14'b0, 4'({1'b0, bar} + 4'd1), k};
  endfunction

  function automatic logic [3:0] note_sel(input logic [63:0] bar, input logic [3:0] idx);
    return bar[{idx, 2'b00} +: 4];
  endfunction

  // Word being returned by the SRAM this cycle, and the next word to address.
  assign cap_idx = 2'(fcnt - CAP_FIRST);
  assign iss_idx = 2'(fcnt + 3'd1);

  always_ff @(posedge i_bclk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      ptr          <= '0;
      fcnt         <= '0;
      bar_buf      <= '0;
      beat_cnt     <= '0;
      note_idx     <= '0;
      o_addr       <= '0;
      o_oe_n       <= 1'b1;
      o_note       <= '0;
      o_note_valid <= 1'b0;
      o_bar        <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_note_valid <= 1'b0;
      if (i_mode || i_stop) begin
        state  <= IDLE;
        o_oe_n <= 1'b1;
        o_note <= '0;
        o_busy <= 1'b0;
      end else if (i_start) begin
        state  <= SEEK;
        ptr    <= '0;
        o_oe_n <= 1'b1;
        o_busy <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          // ---- SEEK: one bar index per cycle ----
          SEEK: begin
            if (i_bar_en[ptr]) begin
              state  <= FETCH;
              fcnt   <= '0;
              o_addr <= word_addr(ptr, 2'd0);
              o_oe_n <= 1'b0;
            end else if (ptr == 3'd7) begin
              if (i_loop && (|i_bar_en)) begin
                ptr <= '0;
              end else begin
                state  <= DONE;
                o_note <= '0;
              end
            end else begin
              ptr <= 3'(ptr + 3'd1);
            end
          end
          // ---- FETCH: issue 4 addresses, capture each RD_LAT later ----
          FETCH: begin
            fcnt <= 3'(fcnt + 3'd1);
            if (fcnt < 3'd3)
              o_addr <= word_addr(ptr, iss_idx);
            if (fcnt >= CAP_FIRST)
              bar_buf[{cap_idx, 4'b0000} +: 16] <= i_SRAM_DQ;
            if (fcnt == CAP_LAST) begin
              state        <= PLAY;
              o_oe_n       <= 1'b1;
              o_bar        <= ptr;
              note_idx     <= '0;
              beat_cnt     <= '0;
              o_note       <= note_sel(bar_buf, 4'd0);
              o_note_valid <= 1'b1;
            end
          end
          // ---- PLAY: one note per BEAT_CYCLES, frozen by pause ----
          PLAY: begin
            if (!i_pause) begin
              if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                if (note_idx == 4'd15) begin
                  if (o_bar != 3'd7) begin
                    ptr   <= 3'(o_bar + 3'd1);
                    state <= SEEK;
                  end else if (i_loop) begin
                    ptr   <= '0;
                    state <= SEEK;
                  end else begin
                    state  <= DONE;
                    o_note <= '0;
                  end
                end else begin
                  note_idx     <= 4'(note_idx + 4'd1);
                  o_note       <= note_sel(bar_buf, 4'(note_idx + 4'd1));
                  o_note_valid <= 1'b1;
                end
              end else begin
                beat_cnt <= CNT_W'(beat_cnt + 1'b1);
              end
            end
          end
          // ---- DONE: single busy cycle before IDLE ----
          DONE: begin
            state  <= IDLE;
            o_note <= '0;
            o_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/sram_bar_player.md
Name: sram_bar_player

Overview:
- Downstream consumer of the SRAM bar store filled by the bar writer.
- Reads back up to 8 stored bars: 64-bit bar, 4 SRAM words per bar.
- Unpacks each bar into 16 four-bit notes and presents them one per beat to the synth/audio stage.
- Owns the SRAM read port only while the write path is inactive (i_mode=0).

Parameters:
- BEAT_CYCLES, 12000000: i_bclk cycles each note is held; minimum 2.
- RD_LAT, 2: cycles from o_addr update to valid data on i_SRAM_DQ; range 1..3.

Ports:
- i_bclk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_mode  in  1  1 = writer owns SRAM; forces player to IDLE.
- i_start  in  1  1-cycle pulse; start playback from bar 0.
- i_stop  in  1  1-cycle pulse; abort playback.
- i_pause  in  1  level; freezes beat timer while high.
- i_loop  in  1  1 = wrap to bar 0 after bar 7.
- i_bar_en  in  8  bar enable mask; bit b enables bar b.
- i_SRAM_DQ  in  16  SRAM read data.
- o_addr  out  20  SRAM address.
- o_oe_n  out  1  SRAM output enable, active-low.
- o_note  out  4  current note code; 0 = rest.
- o_note_valid  out  1  1-cycle pulse at the start of each note.
- o_bar  out  3  index of bar currently playing.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, o_addr=0, o_oe_n=1, o_note=0, o_note_valid=0, o_bar=0, o_busy=0, beat counter=0, note index=0, bar buffer=0. Reset is honoured mid-operation, in any state.
- Storage map:
  - Bar b word k (k=0..3) sits at address {14'b0, (b+1)[3:0], 2'b0} + k, i.e. 4+4b+k.
  - Word k supplies bar bits [16k+15:16k].
- Note order: note n = bar[4n+3:4n], for n = 0..15 (n=0 first).
- States: IDLE, SEEK, FETCH, PLAY, DONE.
- IDLE:
  - o_oe_n=1, o_note=0.
  - i_start (with i_mode=0) -> SEEK with bar pointer 0.
- SEEK:
  - Advances 1 cycle per bar index until an enabled bar is found, then -> FETCH.
  - If pointer reaches 7 and bar 7 is disabled: with i_loop=1 and i_bar_en!=0, wrap to 0 and continue; otherwise -> DONE.
  - i_bar_en is sampled at each SEEK step.
- FETCH:
  - o_oe_n=0. Issues addresses 4+4b+0..3 on consecutive cycles.
  - Captures each word RD_LAT cycles after its address into the bar buffer.
  - After the 4th capture: o_bar=b, note index=0, beat counter=0 -> PLAY.
  - o_oe_n returns to 1 the cycle after the last capture.
- PLAY:
  - On the entry cycle, o_note = note 0 and o_note_valid=1.
  - Beat counter increments each cycle while i_pause=0. On reaching BEAT_CYCLES-1 it clears and the note index increments; the new note is driven with o_note_valid=1.
  - After note 15 expires, pointer = b+1 -> SEEK. If b=7: with i_loop=1 the pointer wraps to 0; otherwise -> DONE.
  - o_note holds its last value during SEEK/FETCH between bars.
- Pause:
  - i_pause=1 freezes the beat counter and note index, holding o_note.
  - i_pause has no effect in SEEK/FETCH; the following PLAY starts frozen if i_pause is still high.
- DONE: o_note=0, o_busy=1 for exactly 1 cycle, then -> IDLE.
- Priority (highest first): reset, then i_mode=1, then i_stop, then i_start, then normal transitions.
  - i_mode=1 or i_stop in any state -> IDLE next cycle, o_oe_n=1 immediately registered, o_note=0. Any in-flight FETCH captures are discarded.
  - i_start while busy restarts from bar 0 (SEEK), discarding the current bar.
  - i_start and i_stop in the same cycle -> IDLE.
- All outputs are registered; no output is driven combinationally from inputs.

Test Plan:
- Load bar 0 = 64'hFEDC_BA98_7654_3210 at addresses 4..7, i_bar_en=8'h01, BEAT_CYCLES=4, RD_LAT=2, i_loop=0, pulse i_start -> addresses 4,5,6,7 issued with o_oe_n=0; notes 0,1,...,F each held 4 cycles with 16 o_note_valid pulses; then DONE and IDLE, o_note=0.
- i_bar_en=8'b1010_0000, i_loop=1 -> fetches at addresses 24..27 (bar 5, o_bar=5), then 32..35 (bar 7), then wraps to bar 5 again; no accesses to other bars.
- i_bar_en=0, i_start -> SEEK through 8 indices, DONE, IDLE; o_oe_n stays 1 throughout.
- During note 3 of bar 0, hold i_pause high for 20 cycles -> o_note stays 3, no o_note_valid; after release, note 3 finishes its remaining beat cycles and then advances to 4.
- Assert i_mode=1 mid-FETCH after 2 words captured -> IDLE next cycle, o_oe_n=1, o_note=0; a later i_start re-fetches from address 4.
- Pulse i_start and i_stop in the same cycle while in PLAY -> IDLE. Assert i_rst low during PLAY -> all outputs take reset values asynchronously.
